// File: rtl/siso_pkg.sv
// rtl/siso_pkg.sv - shared states, block-length constants and LLR saturation for the SISO loader
package siso_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TAIL,
        START,
        BUSY
    } state_t;

    localparam int K_MIN   = 40;
    localparam int K_ALIGN = 8;

    // Clamp a sign-extended sample into the signed data_w range.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] x,
                                                    input int data_w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (data_w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/llr_sat.sv
// rtl/llr_sat.sv - combinational IN_W to DATA_W signed LLR saturator
module llr_sat
    import siso_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DATA_W = 16
) (
    input  logic [IN_W-1:0]   raw,
    output logic [DATA_W-1:0] sat
);

    // Sign-extend to the function width, clamp, keep the low DATA_W bits.
    always_comb begin
        sat = DATA_W'(saturate(32'(signed'(raw)), DATA_W));
    end

endmodule

// File: rtl/siso_block_loader.sv
// rtl/siso_block_loader.sv - block loader feeding saturated sys/par/a-priori LLRs to the SISO decoder
module siso_block_loader
    import siso_pkg::*;
#(
    parameter int IN_W       = 16,
    parameter int DATA_W     = 16,
    parameter int MAX_BLKLEN = 6144,
    parameter int TAIL_BITS  = 3,
    parameter int ADDR_W     = $clog2(MAX_BLKLEN + TAIL_BITS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       blklen,
    input  logic              valid_blklen,
    output logic              ready,
    output logic              blk_err,
    input  logic [IN_W-1:0]   in,
    input  logic              valid_in,
    output logic              in_ready,
    input  logic [IN_W-1:0]   apriori,
    input  logic              valid_apriori,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_sys,
    output logic [DATA_W-1:0] mem_par,
    output logic              apr_we,
    output logic [ADDR_W-1:0] apr_addr,
    output logic [DATA_W-1:0] apr_data,
    output logic              blk_start,
    output logic [15:0]       blk_len,
    input  logic              dec_done
);

    // One extra bit so K+TAIL_BITS never wraps even when it is a power of two.
    localparam int CNT_W = ADDR_W + 1;

    state_t             state;
    state_t             state_next;
    logic [15:0]        k_q;
    logic [CNT_W-1:0]   pair_cnt;
    logic [CNT_W-1:0]   apr_cnt;
    logic [CNT_W-1:0]   k_cnt;
    logic [CNT_W-1:0]   total_cnt;
    logic               phase;
    logic [DATA_W-1:0]  sys_q;
    logic [DATA_W-1:0]  sat_sys;
    logic [DATA_W-1:0]  sat_par;
    logic [DATA_W-1:0]  sat_apr;
    logic               k_ok;
    logic               loading;
    logic               take_in;
    logic               take_apr;
    logic               llr_done;
    logic               apr_done;

    llr_sat #(.IN_W(IN_W), .DATA_W(DATA_W)) u_sat_sys (.raw(in),      .sat(sat_sys));
    llr_sat #(.IN_W(IN_W), .DATA_W(DATA_W)) u_sat_par (.raw(in),      .sat(sat_par));
    llr_sat #(.IN_W(IN_W), .DATA_W(DATA_W)) u_sat_apr (.raw(apriori), .sat(sat_apr));

    assign blk_len = k_q;

    // Block-length legality and sample acceptance qualifiers.
    always_comb begin
        k_cnt     = CNT_W'(k_q);
        total_cnt = k_cnt + CNT_W'(TAIL_BITS);
        k_ok      = (blklen >= 16'(K_MIN)) && (blklen <= 16'(MAX_BLKLEN))
                    && ((blklen & 16'(K_ALIGN - 1)) == 16'd0);
        loading   = (state == LOAD) || (state == TAIL);
        take_in   = loading && valid_in && (pair_cnt < total_cnt);
        take_apr  = loading && valid_apriori && (apr_cnt < k_cnt);
        llr_done  = (pair_cnt == total_cnt);
        apr_done  = (apr_cnt == k_cnt);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        in_ready   = 1'b0;
        blk_start  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (valid_blklen && k_ok) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (llr_done && apr_done) begin
                    state_next = START;
                end else if ((TAIL_BITS != 0) && (pair_cnt >= k_cnt)) begin
                    state_next = TAIL;
                end
            end
            TAIL: begin
                in_ready = 1'b1;
                if (llr_done && apr_done) begin
                    state_next = START;
                end
            end
            START: begin
                blk_start  = 1'b1;
                state_next = BUSY;
            end
            BUSY: begin
                if (dec_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Block setup, sys/par pairing, a-priori writes and registered strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            k_q      <= '0;
            pair_cnt <= '0;
            apr_cnt  <= '0;
            phase    <= 1'b0;
            sys_q    <= '0;
            blk_err  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_sys  <= '0;
            mem_par  <= '0;
            apr_we   <= 1'b0;
            apr_addr <= '0;
            apr_data <= '0;
        end else begin
            mem_we  <= 1'b0;
            apr_we  <= 1'b0;
            blk_err <= 1'b0;

            if ((state == IDLE) && valid_blklen) begin
                if (k_ok) begin
                    k_q      <= blklen;
                    pair_cnt <= '0;
                    apr_cnt  <= '0;
                    phase    <= 1'b0;
                end else begin
                    blk_err <= 1'b1;
                end
            end

            if (take_in) begin
                phase <= ~phase;
                if (!phase) begin
                    sys_q <= sat_sys;
                end else begin
                    mem_we   <= 1'b1;
                    mem_addr <= pair_cnt[ADDR_W-1:0];
                    mem_sys  <= sys_q;
                    mem_par  <= sat_par;
                    pair_cnt <= pair_cnt + CNT_W'(1);
                end
            end

            if (take_apr) begin
                apr_we   <= 1'b1;
                apr_addr <= apr_cnt[ADDR_W-1:0];
                apr_data <= sat_apr;
                apr_cnt  <= apr_cnt + CNT_W'(1);
            end
        end
    end

endmodule
